// File: rtl/cpu_cpu_nios_cpu_ocimem_arbiter_if.sv
// ----------------------------------------------------------------------------
// cpu_cpu_nios_cpu_ocimem_arbiter_if
//
// Avalon-MM debug_mem_slave bundle shared by the OCI memory arbiter and its
// host. The master modport is the Avalon initiator (CPU data master side).
// The slave modport is the arbiter.
//
// Signals:
//   av_address     word address (ADDR_W bits)
//   av_read        read request, held until av_waitrequest is low
//   av_write       write request, held until av_waitrequest is low
//   av_writedata   32-bit write data
//   av_byteenable  4-bit byte lane enables for writes
//   av_readdata    32-bit read data, valid when read and av_waitrequest low
//   av_waitrequest stall; low only in the cycle an access completes
// ----------------------------------------------------------------------------
interface cpu_cpu_nios_cpu_ocimem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [3:0]        av_byteenable;
    logic [31:0]       av_readdata;
    logic              av_waitrequest;

    modport master (
        output av_address,
        output av_read,
        output av_write,
        output av_writedata,
        output av_byteenable,
        input  av_readdata,
        input  av_waitrequest
    );

    modport slave (
        input  av_address,
        input  av_read,
        input  av_write,
        input  av_writedata,
        input  av_byteenable,
        output av_readdata,
        output av_waitrequest
    );
endinterface

// File: rtl/cpu_cpu_nios_cpu_ocimem_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_cpu_nios_cpu_ocimem_arbiter
//
// Shares the single-port OCI debug RAM between the Avalon debug_mem_slave
// port and the JTAG debug-slave command stream, all in the system clock
// domain.
//
// JTAG commands arrive as one-cycle strobes with a 38-bit jdo payload:
//   take_action_ocimem_a     load the JTAG address; if jdo[17] is set also
//                            queue a read at that address (then address+1)
//   take_no_action_ocimem_a  queue a read at the JTAG address, then +1
//   take_action_ocimem_b     queue a full-word write at the JTAG address,
//                            then +1
// Queued JTAG accesses live in a one-deep pending slot. A queueing strobe
// that finds the slot busy is discarded entirely and sets jtag_overrun.
//
// A two-state FSM (IDLE, RD) round-robins the slot against Avalon requests.
// The grant drives the RAM port combinationally in the IDLE cycle. Writes
// finish in that cycle; reads spend one more cycle in RD to collect the
// registered RAM output.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   take_action_ocimem_a/b,
//   take_no_action_ocimem_a,
//   jdo                        JTAG command strobes and payload
//   av                         Avalon slave bundle (interface)
//   ram_addr/ram_wren/
//   ram_byteenable/ram_wdata   RAM port, valid in a grant cycle
//   ram_rdata                  RAM read data, one-cycle registered latency
//   MonDReg                    data of the most recent JTAG read
//   jtag_done                  one-cycle pulse per completed JTAG access
//   jtag_overrun               sticky flag: a JTAG command was dropped
// ----------------------------------------------------------------------------
module cpu_cpu_nios_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                take_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic                take_no_action_ocimem_a,
    input  logic [37:0]         jdo,

    cpu_cpu_nios_cpu_ocimem_arbiter_if.slave av,

    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wren,
    output logic [3:0]          ram_byteenable,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata,

    output logic [31:0]         MonDReg,
    output logic                jtag_done,
    output logic                jtag_overrun
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD      = 1'b1;

    localparam logic       OWNER_AV   = 1'b0;
    localparam logic       OWNER_JTAG = 1'b1;

    localparam logic       OP_RD      = 1'b0;
    localparam logic       OP_WR      = 1'b1;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]        state;
    logic              last_grant;   // owner of the most recent grant
    logic              rd_owner;     // owner of the read in flight (RD)
    logic [ADDR_W-1:0] jtag_addr;

    logic              slot_valid;
    logic              slot_op;
    logic [ADDR_W-1:0] slot_addr;
    logic [31:0]       slot_wdata;

    // ------------------------------------------------------------------
    // JTAG payload fields. Different commands use overlapping bit ranges
    // of jdo, so each field is only meaningful for its own command.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] jdo_addr;
    logic              jdo_rd;
    logic [31:0]       jdo_wdata;

    assign jdo_addr  = jdo[ADDR_W+25:26];
    assign jdo_rd    = jdo[17];
    assign jdo_wdata = jdo[34:3];

    // Remaining jdo bits belong to other debug commands.
    logic unused_jdo;
    assign unused_jdo = ^jdo;

    // ------------------------------------------------------------------
    // Command decode with fixed priority b > a > no_action.
    // ------------------------------------------------------------------
    logic cmd_b;
    logic cmd_a;
    logic cmd_na;
    logic queue_req;

    assign cmd_b     = take_action_ocimem_b;
    assign cmd_a     = take_action_ocimem_a && !take_action_ocimem_b;
    assign cmd_na    = take_no_action_ocimem_a && !take_action_ocimem_a
                       && !take_action_ocimem_b;
    assign queue_req = cmd_b || (cmd_a && jdo_rd) || cmd_na;

    // ------------------------------------------------------------------
    // Arbitration. Grants are only issued from IDLE and never while reset
    // is asserted, so a reset cycle cannot write the RAM or complete an
    // Avalon access.
    // ------------------------------------------------------------------
    logic idle_cycle;
    logic rd_cycle;
    logic av_req;
    logic grant_av;
    logic grant_jtag;

    assign idle_cycle = (state == ST_IDLE) && !reset;
    assign rd_cycle   = (state == ST_RD)   && !reset;
    assign av_req     = av.av_read || av.av_write;

    // On a tie the requester that did not win last time goes first.
    assign grant_av   = idle_cycle && av_req
                        && (!slot_valid || (last_grant == OWNER_JTAG));
    assign grant_jtag = idle_cycle && slot_valid
                        && (!av_req || (last_grant == OWNER_AV));

    // The slot can take a new command if it is empty or is being drained
    // by a grant in this same cycle.
    logic slot_free;
    logic accept;
    logic drop;

    assign slot_free = !slot_valid || grant_jtag;
    assign accept    = queue_req && slot_free;
    assign drop      = queue_req && !slot_free;

    // ------------------------------------------------------------------
    // RAM port mux
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the branches so the
        // block stays purely combinational and cannot infer a latch.
        ram_addr       = '0;
        ram_wren       = 1'b0;
        ram_byteenable = 4'h0;
        ram_wdata      = '0;
        if (grant_av) begin
            ram_addr       = av.av_address;
            ram_wren       = av.av_write;   // read+write together is a write
            ram_byteenable = av.av_byteenable;
            ram_wdata      = av.av_writedata;
        end else if (grant_jtag) begin
            ram_addr       = slot_addr;
            ram_wren       = (slot_op == OP_WR);
            ram_byteenable = 4'hF;
            ram_wdata      = slot_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Avalon response: the stall drops only when an access completes,
    // i.e. in a write grant or in the RD cycle of an Avalon read.
    // ------------------------------------------------------------------
    assign av.av_waitrequest = !((grant_av && av.av_write)
                                 || (rd_cycle && (rd_owner == OWNER_AV)));
    assign av.av_readdata    = ram_rdata;

    // ------------------------------------------------------------------
    // Control state: FSM, arbitration history, JTAG address, slot valid,
    // status outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= OWNER_JTAG;
            jtag_addr    <= '0;
            slot_valid   <= 1'b0;
            MonDReg      <= '0;
            jtag_done    <= 1'b0;
            jtag_overrun <= 1'b0;
        end else begin
            // FSM: only reads leave IDLE; RD always returns to IDLE.
            case (state)
                ST_IDLE: begin
                    if ((grant_av && !av.av_write)
                        || (grant_jtag && (slot_op == OP_RD))) begin
                        state <= ST_RD;
                    end
                end
                ST_RD:   state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (grant_av) begin
                last_grant <= OWNER_AV;
            end else if (grant_jtag) begin
                last_grant <= OWNER_JTAG;
            end

            // Pending slot occupancy.
            if (accept) begin
                slot_valid <= 1'b1;
            end else if (grant_jtag) begin
                slot_valid <= 1'b0;
            end

            // JTAG address: a dropped command leaves it untouched.
            if (cmd_a && !jdo_rd) begin
                jtag_addr <= jdo_addr;
            end else if (accept) begin
                jtag_addr <= (cmd_a ? jdo_addr : jtag_addr) + ADDR_ONE;
            end

            if (drop) begin
                jtag_overrun <= 1'b1;
            end

            if (rd_cycle && (rd_owner == OWNER_JTAG)) begin
                MonDReg <= ram_rdata;
            end

            jtag_done <= (grant_jtag && (slot_op == OP_WR))
                         || (rd_cycle && (rd_owner == OWNER_JTAG));
        end
    end

    // ------------------------------------------------------------------
    // Payload registers. Their contents only matter while slot_valid or
    // the RD state qualifies them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: payload registers are deliberately left out of reset;
        // their valid qualifiers are reset instead, which keeps the reset
        // net off the wide data path.
        if (accept) begin
            slot_op    <= cmd_b ? OP_WR : OP_RD;
            slot_addr  <= cmd_a ? jdo_addr : jtag_addr;
            slot_wdata <= jdo_wdata;
        end
        if (grant_av) begin
            rd_owner <= OWNER_AV;
        end else if (grant_jtag) begin
            rd_owner <= OWNER_JTAG;
        end
    end

endmodule
